// File: rtl/fde_controller_if.sv
// ============================================================================
// Module   : fde_controller_if
// Brief    : Instruction-memory, register-file and status bundle for the
//            fetch-decode-execute sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fde_controller_if #(
  parameter int PC_W = 8
);
  logic            o_imem_req;
  logic [PC_W-1:0] o_imem_addr;
  logic            i_imem_valid;
  logic [15:0]     i_imem_data;
  logic [3:0]      o_read_reg1;
  logic [3:0]      o_read_reg2;
  logic [7:0]      i_read_data1;
  logic [7:0]      i_read_data2;
  logic            o_write_en;
  logic [3:0]      o_write_reg;
  logic [7:0]      o_write_data;
  logic            o_halted;
  logic            o_illegal;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_valid, i_imem_data,
    output o_read_reg1, o_read_reg2,
    input  i_read_data1, i_read_data2,
    output o_write_en, o_write_reg, o_write_data,
    output o_halted, o_illegal
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_valid, i_imem_data,
    input  o_read_reg1, o_read_reg2,
    output i_read_data1, i_read_data2,
    input  o_write_en, o_write_reg, o_write_data,
    input  o_halted, o_illegal
  );
endinterface

`default_nettype wire

// File: rtl/fde_controller.sv
// ============================================================================
// Module   : fde_controller
// Brief    : Fetch-decode-execute sequencer for an 8-bit, 16-register core.
//            Define FDE_CTRL_ILLEGAL_TRAP_EN to trap opcodes A-E into HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fde_controller #(
  parameter int PC_W = 8
) (
  input  wire logic        i_clk,
  input  wire logic        i_reset,
  fde_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_and  = 4'h3;
  localparam logic [3:0] c_op_or   = 4'h4;
  localparam logic [3:0] c_op_xor  = 4'h5;
  localparam logic [3:0] c_op_ldi  = 4'h6;
  localparam logic [3:0] c_op_addi = 4'h7;
  localparam logic [3:0] c_op_jmp  = 4'h8;
  localparam logic [3:0] c_op_jz   = 4'h9;
  localparam logic [3:0] c_op_halt = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic [3:0]      read_reg1_q, read_reg1_d;
  logic [3:0]      read_reg2_q, read_reg2_d;
  logic            write_en_q, write_en_d;
  logic [3:0]      write_reg_q, write_reg_d;
  logic [7:0]      write_data_q, write_data_d;
  logic            halted_q, halted_d;
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
  logic            illegal_q, illegal_d;
`endif

  logic [3:0]      w_op;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_imm;
  logic [7:0]      w_alu;
  logic            w_alu_op;

  assign w_op     = ir_q[15:12];
  assign w_pc_inc = pc_q + PC_W'(1);
  assign w_pc_imm = PC_W'(ir_q[7:0]);

  always_comb begin
    w_alu    = 8'h00;
    w_alu_op = 1'b1;
    case (w_op)
      c_op_add:  w_alu = bus.i_read_data1 + bus.i_read_data2;
      c_op_sub:  w_alu = bus.i_read_data1 - bus.i_read_data2;
      c_op_and:  w_alu = bus.i_read_data1 & bus.i_read_data2;
      c_op_or:   w_alu = bus.i_read_data1 | bus.i_read_data2;
      c_op_xor:  w_alu = bus.i_read_data1 ^ bus.i_read_data2;
      c_op_ldi:  w_alu = ir_q[7:0];
      c_op_addi: w_alu = bus.i_read_data1 + {4'h0, ir_q[3:0]};
      default:   w_alu_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    read_reg1_d  = read_reg1_q;
    read_reg2_d  = read_reg2_q;
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    halted_d     = halted_q;
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        // Request drops for one cycle after reset; valid is ignored until it is up.
        if (!imem_req_q) begin
          imem_req_d = 1'b1;
        end else if (bus.i_imem_valid) begin
          ir_d        = bus.i_imem_data;
          imem_req_d  = 1'b0;
          read_reg1_d = (bus.i_imem_data[15:12] == c_op_jz) ? bus.i_imem_data[11:8]
                                                            : bus.i_imem_data[7:4];
          read_reg2_d = bus.i_imem_data[3:0];
          state_d     = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (w_alu_op) begin
          write_data_d = w_alu;
          write_reg_d  = ir_q[11:8];
          write_en_d   = 1'b1;
          state_d      = S_WB;
        end else begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
          pc_d       = w_pc_inc;
          case (w_op)
            c_op_jmp: pc_d = w_pc_imm;
            c_op_jz:  pc_d = (bus.i_read_data1 == 8'h00) ? w_pc_imm : w_pc_inc;
            c_op_halt: begin
              pc_d       = pc_q;
              imem_req_d = 1'b0;
              halted_d   = 1'b1;
              state_d    = S_HALT;
            end
            c_op_nop: pc_d = w_pc_inc;
            default: begin
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
              pc_d       = pc_q;
              imem_req_d = 1'b0;
              halted_d   = 1'b1;
              illegal_d  = 1'b1;
              state_d    = S_HALT;
`else
              pc_d       = w_pc_inc;
`endif
            end
          endcase
        end
      end
      S_WB: begin
        pc_d       = w_pc_inc;
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      imem_req_q   <= 1'b0;
      read_reg1_q  <= '0;
      read_reg2_q  <= '0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      halted_q     <= 1'b0;
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      read_reg1_q  <= read_reg1_d;
      read_reg2_q  <= read_reg2_d;
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      halted_q     <= halted_d;
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  assign bus.o_imem_req   = imem_req_q;
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_read_reg1  = read_reg1_q;
  assign bus.o_read_reg2  = read_reg2_q;
  // A reset arriving during WB must cancel the write already in flight.
  assign bus.o_write_en   = write_en_q & ~i_reset;
  assign bus.o_write_reg  = write_reg_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_halted     = halted_q;
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
  assign bus.o_illegal    = illegal_q;
`else
  assign bus.o_illegal    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fde_controller.sv
// ============================================================================
// Module   : tb_fde_controller
// Brief    : Self-checking bench for fde_controller with an instruction-level
//            reference model, instruction memory and register file models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fde_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fde_controller_if #(.PC_W(8)) bus();
  fde_controller #(.PC_W(8)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // ---------------- instruction memory model ----------------
  logic [15:0] imem [256];
  int   mem_wait = 0;
  int   wait_cnt = 0;
  logic spur     = 1'b0;
  logic spur_en  = 1'b0;
  logic w_spur_act;

  assign w_spur_act       = spur && !bus.o_imem_req;
  assign bus.i_imem_valid = (bus.o_imem_req && (wait_cnt >= mem_wait)) || w_spur_act;
  assign bus.i_imem_data  = w_spur_act ? 16'hF000 : imem[bus.o_imem_addr];

  always @(posedge clk) begin
    if (rst || !bus.o_imem_req || bus.i_imem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(negedge clk) spur = spur_en && ($urandom_range(0, 2) == 0);

  // ---------------- register file model (r0 hardwired to zero) ----------------
  logic [7:0] rf [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (bus.o_write_en && bus.o_write_reg != 4'd0) begin
      rf[bus.o_write_reg] <= bus.o_write_data;
    end
    bus.i_read_data1 <= rf[bus.o_read_reg1];
    bus.i_read_data2 <= rf[bus.o_read_reg2];
  end

  // ---------------- observation ----------------
  typedef struct packed { logic [3:0] r; logic [7:0] d; int cyc; } wr_t;
  typedef struct packed { logic [7:0] a; int cyc; } fe_t;
  wr_t wq[$];
  fe_t fq[$];
  int  cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (bus.o_write_en) wq.push_back('{r: bus.o_write_reg, d: bus.o_write_data, cyc: cyc});
      if (bus.o_imem_req && bus.i_imem_valid) fq.push_back('{a: bus.o_imem_addr, cyc: cyc});
    end
  end

  // ---------------- instruction-level reference model ----------------
  logic [7:0]  exp_f[$];
  logic [11:0] exp_w[$];
  bit          exp_halt;
  bit          exp_ill;

  task automatic model_run(input int k);
    logic [7:0]  r [16];
    logic [7:0]  pc = 8'h00;
    logic [15:0] ins;
    logic [7:0]  a, b, v;
    bit          wr;
    exp_f.delete();
    exp_w.delete();
    exp_halt = 1'b0;
    exp_ill  = 1'b0;
    for (int i = 0; i < 16; i++) r[i] = 8'h00;
    for (int s = 0; s <= k; s++) begin
      exp_f.push_back(pc);
      if (s == k) break;
      ins = imem[pc];
      a   = r[ins[7:4]];
      b   = r[ins[3:0]];
      v   = 8'h00;
      wr  = 1'b1;
      case (ins[15:12])
        4'h1: v = a + b;
        4'h2: v = a - b;
        4'h3: v = a & b;
        4'h4: v = a | b;
        4'h5: v = a ^ b;
        4'h6: v = ins[7:0];
        4'h7: v = a + {4'h0, ins[3:0]};
        default: wr = 1'b0;
      endcase
      if (wr) begin
        exp_w.push_back({ins[11:8], v});
        if (ins[11:8] != 4'd0) r[ins[11:8]] = v;
        pc = pc + 8'd1;
      end else if (ins[15:12] == 4'h8) begin
        pc = ins[7:0];
      end else if (ins[15:12] == 4'h9) begin
        pc = (r[ins[11:8]] == 8'h00) ? ins[7:0] : pc + 8'd1;
      end else if (ins[15:12] == 4'hF) begin
        exp_halt = 1'b1;
        break;
      end else if (ins[15:12] >= 4'hA) begin
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
        exp_halt = 1'b1;
        exp_ill  = 1'b1;
        break;
`else
        pc = pc + 8'd1;
`endif
      end else begin
        pc = pc + 8'd1;
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    int k = $urandom_range(0, 39);
    logic [3:0] op;
    if (k < 24)      op = 4'($urandom_range(1, 7));
    else if (k < 30) op = 4'h9;
    else if (k < 33) op = 4'h8;
    else if (k < 37) op = 4'h0;
    else if (k < 39) op = 4'($urandom_range(10, 14));
    else             op = 4'hF;
    return {op, 12'($urandom())};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wq.delete();
    fq.delete();
  endtask

  task automatic wait_done(input int nfetch, input bit want_halt, input int budget);
    int n = 0;
    while ((want_halt ? !bus.o_halted : (fq.size() < nfetch)) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (want_halt ? !bus.o_halted : (fq.size() < nfetch)) begin
      errors++;
      $display("FAIL timeout: fetched %0d (need %0d) halted=%0b within %0d cycles",
               fq.size(), nfetch, bus.o_halted, budget);
    end
    if (want_halt) repeat (3) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fill_halt();
    imem[0] = 16'h6105;
    do_reset();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr, bus.o_read_reg1, bus.o_read_reg2, bus.o_write_en,
         bus.o_write_reg, bus.o_write_data, bus.o_halted, bus.o_illegal} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h rr1=%h rr2=%h we=%b wr=%h wd=%h h=%b il=%b want all 0",
               bus.o_imem_req, bus.o_imem_addr, bus.o_read_reg1, bus.o_read_reg2, bus.o_write_en,
               bus.o_write_reg, bus.o_write_data, bus.o_halted, bus.o_illegal);
    end
    tick();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00", bus.o_imem_req, bus.o_imem_addr);
    end
  endtask

  task automatic test_alu();
    logic [11:0] ew [5] = '{12'h105, 12'h2FB, 12'h300, 12'h4FB, 12'h514};
    fill_halt();
    imem[0] = 16'h6105;  imem[1] = 16'h62FB;  imem[2] = 16'h1312;
    imem[3] = 16'h2401;  imem[4] = 16'h751F;
    do_reset();
    wait_done(6, 1'b1, 200);
    checks++;
    if (wq.size() != 5) begin
      errors++;
      $display("FAIL alu_write_count: got %0d want 5", wq.size());
    end
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      checks++;
      if ({wq[i].r, wq[i].d} !== ew[i]) begin
        errors++;
        $display("FAIL alu_write%0d: got %h want %h", i, {wq[i].r, wq[i].d}, ew[i]);
      end
    end
    checks++;
    if (fq.size() < 4 || (fq[3].cyc - fq[0].cyc) != 12) begin
      errors++;
      $display("FAIL alu_cycles: got %0d want 12", (fq.size() < 4) ? -1 : fq[3].cyc - fq[0].cyc);
    end
  endtask

  task automatic test_branch();
    logic [7:0] ef [6] = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h30, 8'h31};
    fill_halt();
    imem[8'h00] = 16'h6105;  imem[8'h01] = 16'h9020;  imem[8'h20] = 16'h9120;
    imem[8'h21] = 16'h8030;  imem[8'h30] = 16'h0000;
    do_reset();
    wait_done(6, 1'b1, 200);
    checks++;
    if (fq.size() != 6 || wq.size() != 1) begin
      errors++;
      $display("FAIL branch_counts: got fetches=%0d writes=%0d want 6 and 1", fq.size(), wq.size());
    end
    for (int i = 0; i < 6 && i < fq.size(); i++) begin
      checks++;
      if (fq[i].a !== ef[i]) begin
        errors++;
        $display("FAIL branch_fetch%0d: got %h want %h", i, fq[i].a, ef[i]);
      end
    end
    checks++;
    if (fq.size() < 6 || (fq[2].cyc - fq[1].cyc) != 3 || (fq[5].cyc - fq[4].cyc) != 3) begin
      errors++;
      $display("FAIL branch_cycles: JZ/NOP instruction length not 3 cycles");
    end
  endtask

  task automatic test_wait_states();
    int run = 0;
    bit addr_ok = 1'b1;
    fill_halt();
    imem[0] = 16'h6105;  imem[1] = 16'h751F;
    mem_wait = 3;
    spur_en  = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (bus.o_imem_req) begin
        run++;
        if (bus.o_imem_addr !== 8'h00) addr_ok = 1'b0;
        if (bus.i_imem_valid) break;
      end
      tick();
    end
    checks++;
    if (run != 4 || !addr_ok) begin
      errors++;
      $display("FAIL wait_req_hold: got %0d cycles addr_stable=%0b want 4 and 1", run, addr_ok);
    end
    wait_done(3, 1'b1, 300);
    checks++;
    if (wq.size() != 2 || (wq.size() == 2 && ({wq[0].r, wq[0].d, wq[1].r, wq[1].d} !== 24'h105514))) begin
      errors++;
      $display("FAIL wait_writes: got %0d writes want (1,05) (5,14)", wq.size());
    end
    spur_en  = 1'b0;
    mem_wait = 0;
  endtask

  task automatic test_reset_in_wb();
    int n0;
    int n = 0;
    bit hit3 = 1'b0;
    fill_halt();
    imem[0] = 16'h6105;  imem[1] = 16'h6207;  imem[2] = 16'h1312;
    do_reset();
    wait_done(3, 1'b0, 100);
    tick();
    tick();
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    checks++;
    if (bus.o_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_we: got %b want 0", bus.o_write_en);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = fq.size();
    while (fq.size() <= n0 && n < 20) begin
      tick();
      n++;
    end
    foreach (wq[i]) if (wq[i].r == 4'd3) hit3 = 1'b1;
    checks++;
    if (fq.size() <= n0 || fq[n0].a !== 8'h00 || hit3 || wq.size() != 2) begin
      errors++;
      $display("FAIL reset_wb_refetch: got addr=%h writes=%0d r3_written=%0b want addr=00 writes=2 r3=0",
               (fq.size() > n0) ? fq[n0].a : 8'hxx, wq.size(), hit3);
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] ef [3] = '{8'h00, 8'hFF, 8'h00};
    fill_halt();
    imem[8'h00] = 16'h80FF;
    imem[8'hFF] = 16'h0000;
    do_reset();
    wait_done(3, 1'b0, 100);
    for (int i = 0; i < 3 && i < fq.size(); i++) begin
      checks++;
      if (fq[i].a !== ef[i]) begin
        errors++;
        $display("FAIL wrap_fetch%0d: got %h want %h", i, fq[i].a, ef[i]);
      end
    end
  endtask

  task automatic test_illegal();
    fill_halt();
    imem[0] = 16'h6105;  imem[1] = 16'hB000;  imem[2] = 16'h6203;
    do_reset();
    wait_done(0, 1'b1, 200);
`ifdef FDE_CTRL_ILLEGAL_TRAP_EN
    checks++;
    if ({bus.o_illegal, bus.o_halted, bus.o_imem_req, bus.o_imem_addr} !== {3'b110, 8'h01} ||
        fq.size() != 2 || wq.size() != 1) begin
      errors++;
      $display("FAIL illegal_trap: got il=%b h=%b req=%b addr=%h fetches=%0d writes=%0d want 1 1 0 01 2 1",
               bus.o_illegal, bus.o_halted, bus.o_imem_req, bus.o_imem_addr, fq.size(), wq.size());
    end
`else
    checks++;
    if (bus.o_illegal !== 1'b0 || fq.size() != 4 || wq.size() != 2 ||
        (wq.size() == 2 && {wq[1].r, wq[1].d} !== 12'h203) || (fq.size() > 2 && fq[2].a !== 8'h02)) begin
      errors++;
      $display("FAIL illegal_as_nop: got il=%b fetches=%0d writes=%0d want 0 4 2",
               bus.o_illegal, fq.size(), wq.size());
    end
`endif
  endtask

  task automatic test_halt();
    bit req_seen = 1'b0;
    fill_halt();
    do_reset();
    wait_done(0, 1'b1, 50);
    repeat (5) begin
      tick();
      if (bus.o_imem_req !== 1'b0 || bus.o_halted !== 1'b1) req_seen = 1'b1;
    end
    checks++;
    if (req_seen || fq.size() != 1 || wq.size() != 0 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: got req_or_unhalt=%0b fetches=%0d writes=%0d il=%b want 0 1 0 0",
               req_seen, fq.size(), wq.size(), bus.o_illegal);
    end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
      mem_wait = $urandom_range(0, 2);
      spur_en  = 1'b1;
      model_run(30);
      do_reset();
      wait_done(exp_f.size(), exp_halt, 1500);
      checks++;
      if (fq.size() != exp_f.size() || wq.size() != exp_w.size()) begin
        errors++;
        $display("FAIL rand%0d_counts: got fetches=%0d writes=%0d want %0d %0d",
                 it, fq.size(), wq.size(), exp_f.size(), exp_w.size());
      end
      for (int i = 0; i < fq.size() && i < exp_f.size(); i++) begin
        checks++;
        if (fq[i].a !== exp_f[i]) begin
          errors++;
          $display("FAIL rand%0d_fetch%0d: got %h want %h", it, i, fq[i].a, exp_f[i]);
        end
      end
      for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
        checks++;
        if ({wq[i].r, wq[i].d} !== exp_w[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %h want %h", it, i, {wq[i].r, wq[i].d}, exp_w[i]);
        end
      end
      checks++;
      if (bus.o_halted !== exp_halt || bus.o_illegal !== exp_ill) begin
        errors++;
        $display("FAIL rand%0d_status: got h=%b il=%b want h=%b il=%b",
                 it, bus.o_halted, bus.o_illegal, exp_halt, exp_ill);
      end
    end
    spur_en  = 1'b0;
    mem_wait = 0;
  endtask

  initial begin
    fill_halt();
    test_reset();
    test_alu();
    test_branch();
    test_wait_states();
    test_reset_in_wb();
    test_pc_wrap();
    test_illegal();
    test_halt();
    test_random(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
